// File: rtl/uart_rx_monitor.sv
// UART receive link checker: deserialises frames, compares each byte with EXPECT_DATA, counts hits/errors, flags link timeout.
// Optional build macro UART_RX_PARITY_EN switches the frame from 8N1 to 8E1 with parity checking.
`timescale 1ns/1ps

module uart_rx_monitor #(
  parameter int         CLK_FREQ    = 50_000_000,
  parameter int         UART_BPS    = 115200,
  parameter logic [7:0] EXPECT_DATA = 8'h55,
  parameter int         TIMEOUT_MS  = 200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rxd,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_frame_err,
  output logic        rx_busy,
  output logic [15:0] match_cnt,
  output logic [15:0] err_cnt,
  output logic        link_timeout
);

  localparam int BAUD_CNT_MAX    = CLK_FREQ / UART_BPS;
  localparam int TIMEOUT_CNT_MAX = CLK_FREQ / 1_000 * TIMEOUT_MS;
  localparam int BAUD_W          = $clog2(BAUD_CNT_MAX);
  localparam int TMO_W           = $clog2(TIMEOUT_CNT_MAX);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_CNT_MAX - 1);
  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(BAUD_CNT_MAX / 2 - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CNT_MAX - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } state_t;

  state_t            state;
  logic              rxd_p0, rxd_p1, rxd_p2;
  logic              line, fall;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;
  logic [TMO_W-1:0]  tmo_cnt;
`ifdef UART_RX_PARITY_EN
  logic              par_err;
`endif

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Stage p0/p1: two-FF synchroniser; p2 holds the previous synced value for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_p0 <= 1'b1;
      rxd_p1 <= 1'b1;
      rxd_p2 <= 1'b1;
    end else begin
      rxd_p0 <= uart_rxd;
      rxd_p1 <= rxd_p0;
      rxd_p2 <= rxd_p1;
    end
  end

  assign line = rxd_p1;
  assign fall = rxd_p2 & ~rxd_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      baud_cnt     <= '0;
      bit_idx      <= '0;
      shift        <= '0;
`ifdef UART_RX_PARITY_EN
      par_err      <= 1'b0;
`endif
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_busy      <= 1'b0;
      match_cnt    <= '0;
      err_cnt      <= '0;
      tmo_cnt      <= '0;
      link_timeout <= 1'b0;
    end else begin
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      // A good byte completing in this cycle overrides the timeout below
      if (tmo_cnt == TMO_LAST) link_timeout <= 1'b1;
      else                     tmo_cnt      <= tmo_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (fall) begin
            state    <= START;
            baud_cnt <= '0;
            rx_busy  <= 1'b1;
          end
        end
        START: begin
          if (baud_cnt == BAUD_HALF) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            if (line) begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end else begin
              state <= DATA;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            shift    <= {line, shift[7:1]};
            bit_idx  <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            par_err  <= line ^ (^shift);
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (!line) begin
              rx_frame_err <= 1'b1;
              err_cnt      <= sat_inc(err_cnt);
              state        <= WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
            end else if (par_err) begin
              rx_frame_err <= 1'b1;
              err_cnt      <= sat_inc(err_cnt);
              state        <= IDLE;
              rx_busy      <= 1'b0;
`endif
            end else begin
              rx_data      <= shift;
              rx_valid     <= 1'b1;
              tmo_cnt      <= '0;
              link_timeout <= 1'b0;
              if (shift == EXPECT_DATA) match_cnt <= sat_inc(match_cnt);
              else                      err_cnt   <= sat_inc(err_cnt);
              state        <= IDLE;
              rx_busy      <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (line) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Directed bench for uart_rx_monitor: expected bytes are queued as frames are driven and popped on rx_valid.
`timescale 1ns/1ps

module tb_uart_rx_monitor;
  localparam int BIT = 434;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_rxd = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_frame_err;
  logic        rx_busy;
  logic [15:0] match_cnt;
  logic [15:0] err_cnt;
  logic        link_timeout;

  int         checks = 0;
  int         errors = 0;
  int         n_valid = 0;
  int         n_ferr = 0;
  int         cyc = 0;
  int         exp_match = 0;
  int         exp_err = 0;
  int         exp_ferr = 0;
  int         rel = 0;
  int         nv_before = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_byte;

  always #10 clk = ~clk;

  uart_rx_monitor #(
    .CLK_FREQ(50_000_000),
    .UART_BPS(115200),
    .EXPECT_DATA(8'h55),
    .TIMEOUT_MS(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .uart_rxd(uart_rxd),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_frame_err(rx_frame_err),
    .rx_busy(rx_busy),
    .match_cnt(match_cnt),
    .err_cnt(err_cnt),
    .link_timeout(link_timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: pops the scoreboard on every rx_valid pulse
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      n_valid++;
      check("valid_timeout_clr", {31'b0, link_timeout}, 32'd0);
      if (exp_q.size() == 0) begin
        check("sb_nonempty", exp_q.size(), 32'd1);
      end else begin
        exp_byte = exp_q.pop_front();
        check("sb_rx_data", {24'b0, rx_data}, {24'b0, exp_byte});
      end
    end
    if (rx_frame_err === 1'b1) n_ferr++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    uart_rxd = b;
    tick(BIT);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^d);
`endif
    drive_bit(stop_bit);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_bad_parity(input logic [7:0] d);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(~^d);
    drive_bit(1'b1);
  endtask
`endif

  task automatic expect_byte(input logic [7:0] d);
    exp_q.push_back(d);
    if (d == 8'h55) exp_match++;
    else            exp_err++;
  endtask

  task automatic apply_reset();
    uart_rxd = 1'b1;
    rst_n = 1'b0;
    tick(3);
    exp_q.delete();
    exp_match = 0;
    exp_err = 0;
    rst_n = 1'b1;
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_match"}, {16'b0, match_cnt}, exp_match);
    check({tag, "_err"}, {16'b0, err_cnt}, exp_err);
    check({tag, "_ferr"}, n_ferr, exp_ferr);
    check({tag, "_sb_empty"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    tick(2);
    check("rst_rx_data", {24'b0, rx_data}, 32'd0);
    check("rst_rx_valid", {31'b0, rx_valid}, 32'd0);
    check("rst_frame_err", {31'b0, rx_frame_err}, 32'd0);
    check("rst_busy", {31'b0, rx_busy}, 32'd0);
    check("rst_match", {16'b0, match_cnt}, 32'd0);
    check("rst_err", {16'b0, err_cnt}, 32'd0);
    check("rst_timeout", {31'b0, link_timeout}, 32'd0);
    rst_n = 1'b1;
    tick(5);

    // Single 0x55 frame
    expect_byte(8'h55);
    send_frame(8'h55, 1'b1);
    tick(BIT);
    check("t1_rx_data", {24'b0, rx_data}, 32'h55);
    check("t1_busy", {31'b0, rx_busy}, 32'd0);
    check("t1_nvalid", n_valid, 32'd1);
    check_counts("t1");

    // 0xA3 then three back-to-back 0x55 frames
    expect_byte(8'hA3);
    send_frame(8'hA3, 1'b1);
    for (int k = 0; k < 3; k++) begin
      expect_byte(8'h55);
      send_frame(8'h55, 1'b1);
    end
    tick(BIT);
    check("t2_nvalid", n_valid, 32'd5);
    check("t2_rx_data", {24'b0, rx_data}, 32'h55);
    check_counts("t2");

    // Glitch, framing error with break hold, then link timeout, all inside one timeout window
    apply_reset();
    rel = cyc;
    nv_before = n_valid;
    uart_rxd = 1'b0;
    tick(50);
    check("t4_busy_glitch", {31'b0, rx_busy}, 32'd1);
    tick(50);
    uart_rxd = 1'b1;
    tick(300);
    check("t4_busy_after", {31'b0, rx_busy}, 32'd0);
    check("t4_nvalid", n_valid, nv_before);
    check_counts("t4");

    exp_err++;
    exp_ferr++;
    send_frame(8'h55, 1'b0);
    tick(20 * BIT);
    check("t3_busy_hold", {31'b0, rx_busy}, 32'd1);
    check("t3_nvalid", n_valid, nv_before);
    check("t3_rx_data", {24'b0, rx_data}, 32'd0);
    check_counts("t3_hold");
    uart_rxd = 1'b1;
    tick(2 * BIT);
    check("t3_busy_idle", {31'b0, rx_busy}, 32'd0);

    while (cyc < rel + 49_900) tick(1);
    check("t5_timeout_early", {31'b0, link_timeout}, 32'd0);
    while (cyc < rel + 50_100) tick(1);
    check("t5_timeout_set", {31'b0, link_timeout}, 32'd1);

    expect_byte(8'h55);
    send_frame(8'h55, 1'b1);
    tick(BIT);
    check("t5_timeout_clr", {31'b0, link_timeout}, 32'd0);
    check("t3_nvalid2", n_valid, nv_before + 1);
    check_counts("t3_t5");

    // Reset asserted in the middle of the data bits
    uart_rxd = 1'b0;
    tick(BIT);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    tick(BIT / 2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rx_data", {24'b0, rx_data}, 32'd0);
    check("mid_rst_busy", {31'b0, rx_busy}, 32'd0);
    check("mid_rst_match", {16'b0, match_cnt}, 32'd0);
    check("mid_rst_err", {16'b0, err_cnt}, 32'd0);
    check("mid_rst_timeout", {31'b0, link_timeout}, 32'd0);
    uart_rxd = 1'b1;
    tick(3);
    exp_q.delete();
    exp_match = 0;
    exp_err = 0;
    rst_n = 1'b1;
    tick(2 * BIT);
    nv_before = n_valid;
    expect_byte(8'h55);
    send_frame(8'h55, 1'b1);
    tick(BIT);
    check("t6_nvalid", n_valid, nv_before + 1);
    check("t6_rx_data", {24'b0, rx_data}, 32'h55);
    check_counts("t6");

`ifdef UART_RX_PARITY_EN
    // Even parity: good parity accepted, bad parity reported and byte dropped
    expect_byte(8'h55);
    send_frame(8'h55, 1'b1);
    tick(BIT);
    check_counts("par_good");
    nv_before = n_valid;
    exp_err++;
    exp_ferr++;
    send_bad_parity(8'h55);
    tick(BIT);
    check("par_bad_nvalid", n_valid, nv_before);
    check("par_bad_rx_data", {24'b0, rx_data}, 32'h55);
    check("par_bad_busy", {31'b0, rx_busy}, 32'd0);
    check_counts("par_bad");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
